vga_fb_arbiter: RTL
===================

# vga_fb_arbiter

Single-port framebuffer arbiter between the VGA timing controller's pixel-request path and a pixel writer (drawing engine/CPU bridge). It turns `pix_x`/`pix_y` requests into 2×-downscaled framebuffer reads (320×240 RGB565, 76 800 words) and returns `pix_data` with one-cycle latency. The display path has absolute priority. Writes are buffered and drained only in cycles where the display issues no request (blanking). It sits between the VGA timing controller and the framebuffer RAM.

## Interface
Parameters:
- `WFIFO_DEPTH`, 8: write FIFO entries, power of 2, ≥2; used only with `VGA_FB_WR_FIFO_EN`.
- `FB_BASE`, 17'd0: word offset added to every framebuffer address.

Ports (reset: sys_rst_n, asynchronous, active-low; clock: vga_clk):
- `vga_clk`  in  1  pixel clock, 25 MHz
- `sys_rst_n`  in  1  async active-low reset
- `pix_x`  in  10  requested X, 10'h3ff = no request
- `pix_y`  in  10  requested Y, 10'h3ff = no request
- `pix_data`  out  16  RGB565 back to the timing controller
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready`
- `wr_addr`  in  17  framebuffer word address, 0..76799
- `wr_data`  in  16  RGB565 write data
- `mem_addr`  out  17  RAM address
- `mem_we`  out  1  RAM write enable
- `mem_wdata`  out  16  RAM write data
- `mem_rdata`  in  16  RAM read data, valid 1 cycle after address (registered RAM)
- `wr_err`  out  1  sticky out-of-range write flag
- `fifo_level`  out  $clog2(WFIFO_DEPTH)+1  current write FIFO occupancy

## Operation
- A display request occurs when `pix_x != 10'h3ff`. Display address = `FB_BASE + pix_y[9:1]*320 + pix_x[9:1]`, built as `(y<<8)+(y<<6)+x`, 17-bit, no wrap.
- Arbiter FSM states:
  - `S_DISP`: display owns the port. `mem_we=0`. Moves to `S_WR` on the first cycle with no request while a write is pending.
  - `S_WR`: one write per cycle (FIFO head, or the direct request). Returns to `S_DISP` in the same cycle a request reappears; the display is never stalled.
  - `S_IDLE`: no request and nothing pending.
- `rd_pend` register = display request in the previous cycle. `pix_data = rd_pend ? mem_rdata : 16'h0`.
- A write is out of range when `wr_addr >= 76800`. It is accepted normally but never reaches RAM (`mem_we` held 0). `wr_err` sets and stays set until reset.
- Simultaneous display request and pending write: display wins, the write waits, no data is lost.
- `wr_valid` deasserting without handshake is legal; there is no commitment before acceptance.

## Timing
- Reset values: `pix_data=0`, `wr_ready=0` (with FIFO) or combinational per the rule below, `mem_we=0`, `wr_err=0`, `fifo_level=0`, FSM=`S_IDLE`. FIFO contents are discarded.
- Read latency is exactly 1 cycle, request to `pix_data`, which aligns with the timing controller's valid window.
- `mem_addr`/`mem_we`/`mem_wdata` are combinational from state and inputs, so RAM sees the address in the request cycle.
- Write throughput: 1 per blanking cycle, giving ≥160 per line.
- Reset asserted mid-frame or mid-write: outputs go to reset values immediately. Any RAM write in flight that cycle is not guaranteed.

## Configuration
`VGA_FB_WR_FIFO_EN`:
- Defined: `fb_wr_fifo` is instantiated with depth `WFIFO_DEPTH`.
  - `wr_ready = !full`, registered.
  - Push and pop in the same cycle are legal when not empty.
  - Level is unchanged on simultaneous push and pop.
  - Push is blocked at full; pop is blocked at empty.
- Undefined: no buffering.
  - `wr_ready = (pix_x == 10'h3ff)`, combinational.
  - An accepted write goes to RAM in the same cycle.
  - `fifo_level` is tied to 0.

## Structure
- `vga_fb_pkg` holds: `FB_W=320`, `FB_H=240`, `FB_WORDS=76800`, `FB_AW=17`, `NULL_COORD=10'h3ff`, the FSM state enum, and the write-entry struct `{addr[16:0], data[15:0]}`.
- Sub-module `fb_wr_fifo`: synchronous FIFO with power-of-2 depth, wrap-around pointers plus one extra bit for full/empty, and a `level` output.

## Test plan
- Read path: `pix_x=0, pix_y=0` then `pix_x=639, pix_y=479`, with RAM modelled as data = address. Required: `mem_addr` 0 then 76799; `pix_data` 0x0000 then 0x2BFF (low 16 bits of 76799), each one cycle later; 0 when `rd_pend=0`.
- Priority: `wr_valid` held during active video, `wr_addr=100`, `wr_data=16'hF800`. Required: `mem_we=0` throughout active video; the write lands on the first cycle with `pix_x=3ff`; a later read of (200,0) returns F800.
- FIFO full (macro on): push 9 writes with no blanking. Required: 8 accepted, `fifo_level=8`, `wr_ready=0`. At blanking: 8 consecutive `mem_we` cycles in FIFO order, level falls to 0.
- Out-of-range: `wr_addr=76800`. Required: handshake completes, no `mem_we`, `wr_err=1` and sticky.
- Reset mid-frame with 3 queued writes. Required: all reset values hold, `fifo_level=0`, and the queued writes never appear on `mem_we` after release.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// -----------------------------------------------------------------------------
// vga_fb_pkg
// Shared constants, types and helpers for the VGA framebuffer arbiter.
//   FB_W / FB_H / FB_WORDS : 320x240 RGB565 framebuffer geometry
//   FB_AW                  : framebuffer word-address width
//   NULL_COORD             : pix_x value that means "no display request"
//   arb_state_t            : arbiter port-owner state
//   wr_entry_t             : buffered write {addr, data}
//   disp_offset()          : row*320 + col, built from shifts and adds
// -----------------------------------------------------------------------------
package vga_fb_pkg;

  localparam int FB_W  = 320;
  localparam int FB_H  = 240;
  localparam int FB_AW = 17;

  localparam logic [FB_AW-1:0] FB_WORDS   = FB_AW'(FB_W * FB_H);
  localparam logic [9:0]       NULL_COORD = 10'h3ff;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DISP = 2'd1,
    S_WR   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [FB_AW-1:0] addr;
    logic [15:0]      data;
  } wr_entry_t;

  // row*320 = row*256 + row*64; no multiplier needed.
  function automatic logic [FB_AW-1:0] disp_offset(input logic [8:0] col,
                                                   input logic [8:0] row);
    logic [FB_AW-1:0] r;
    r = {8'd0, row};
    return (r << 8) + (r << 6) + {8'd0, col};
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// fb_wr_fifo
// Synchronous write FIFO for the framebuffer arbiter. Power-of-2 depth,
// wrap-around pointers carrying one extra bit to tell full from empty.
// Ports:
//   vga_clk, sys_rst_n : clock, async active-low reset
//   push, push_entry   : enqueue request (ignored when full)
//   pop                : dequeue request (ignored when empty)
//   head               : entry at the read pointer (valid when !empty)
//   empty              : no entries stored
//   not_full           : registered "can accept"; 0 during and right after reset
//   level              : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fb_wr_fifo
  import vga_fb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     vga_clk,
  input  logic                     sys_rst_n,
  input  logic                     push,
  input  wr_entry_t                push_entry,
  input  logic                     pop,
  output wr_entry_t                head,
  output logic                     empty,
  output logic                     not_full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  wr_entry_t   mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] level_nxt;
  logic        push_ok;
  logic        pop_ok;

  assign level   = wptr - rptr;
  assign empty   = (level == '0);
  assign push_ok = push && (level != FULL_LVL);
  assign pop_ok  = pop && !empty;
  assign head    = mem[rptr[AW-1:0]];

  assign level_nxt = level + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      not_full <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      not_full <= (level_nxt != FULL_LVL);
    end
  end

  // NOTE: storage is deliberately not reset; resetting the pointers already
  // discards the contents and keeps the array mappable to plain RAM/regs.
  always_ff @(posedge vga_clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
// Single-port framebuffer arbiter. The VGA display path (pix_x/pix_y, 2x
// downscaled into a 320x240 RGB565 buffer) has absolute priority; pixel
// writes go to RAM only in cycles with no display request (blanking).
// Build option: define VGA_FB_WR_FIFO_EN to buffer writes in fb_wr_fifo
// (WFIFO_DEPTH entries); otherwise writes pass straight through and are
// only accepted during blanking.
// Ports:
//   vga_clk, sys_rst_n            : pixel clock, async active-low reset
//   pix_x, pix_y, pix_data        : display request (pix_x=3ff: none) and
//                                   RGB565 result one cycle later
//   wr_valid, wr_ready,
//   wr_addr, wr_data              : write request handshake
//   mem_addr, mem_we, mem_wdata,
//   mem_rdata                     : registered single-port RAM interface
//   wr_err                        : sticky out-of-range write flag
//   fifo_level                    : write FIFO occupancy (0 without FIFO)
// -----------------------------------------------------------------------------
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int          WFIFO_DEPTH = 8,
  parameter logic [16:0] FB_BASE     = 17'd0
) (
  input  logic                         vga_clk,
  input  logic                         sys_rst_n,
  input  logic [9:0]                   pix_x,
  input  logic [9:0]                   pix_y,
  output logic [15:0]                  pix_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [16:0]                  wr_addr,
  input  logic [15:0]                  wr_data,
  output logic [16:0]                  mem_addr,
  output logic                         mem_we,
  output logic [15:0]                  mem_wdata,
  input  logic [15:0]                  mem_rdata,
  output logic                         wr_err,
  output logic [$clog2(WFIFO_DEPTH):0] fifo_level
);

  arb_state_t  state;
  logic        disp_req;
  logic        rd_pend;
  logic [16:0] rd_addr;
  logic        in_range;
  logic        accept;
  logic        wr_go;
  wr_entry_t   wr_src;
  logic        unused_lsb;

  // The 2x downscale drops coordinate bit 0.
  assign unused_lsb = pix_x[0] ^ pix_y[0];

  assign disp_req = (pix_x != NULL_COORD);
  assign rd_addr  = FB_BASE + disp_offset(pix_x[9:1], pix_y[9:1]);
  assign in_range = (wr_addr < FB_WORDS);
  assign accept   = wr_valid && wr_ready;

`ifdef VGA_FB_WR_FIFO_EN
  wr_entry_t in_entry;
  logic      fifo_empty;

  assign in_entry = '{addr: wr_addr, data: wr_data};

  // Out-of-range writes complete the handshake but are never queued.
  fb_wr_fifo #(
    .DEPTH(WFIFO_DEPTH)
  ) u_wr_fifo (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .push      (accept && in_range),
    .push_entry(in_entry),
    .pop       (wr_go),
    .head      (wr_src),
    .empty     (fifo_empty),
    .not_full  (wr_ready),
    .level     (fifo_level)
  );

  assign wr_go = !disp_req && !fifo_empty;
`else
  // Without buffering a write is accepted only when it can hit RAM now.
  assign wr_ready   = !disp_req;
  assign wr_go      = accept && in_range && sys_rst_n;
  assign wr_src     = '{addr: wr_addr, data: wr_data};
  assign fifo_level = '0;
`endif

  // RAM sees the address in the request cycle; display wins by construction
  // because wr_go is only ever true when disp_req is low.
  assign mem_we    = wr_go;
  assign mem_addr  = wr_go ? (FB_BASE + wr_src.addr) : rd_addr;
  assign mem_wdata = wr_src.data;

  // state records who owned the port in the previous cycle, so S_DISP here
  // means the registered RAM is returning a display word this cycle.
  assign rd_pend  = (state == S_DISP);
  assign pix_data = rd_pend ? mem_rdata : 16'h0000;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_DISP, S_WR, S_IDLE: begin
          if (disp_req)   state <= S_DISP;
          else if (wr_go) state <= S_WR;
          else            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_err <= 1'b0;
    end else if (accept && !in_range) begin
      wr_err <= 1'b1;
    end
  end

endmodule
